// File: rtl/trap_sequencer_pkg.sv
// Shared definitions for the trap sequencer: FSM states, default cause codes
// and the mcause encoding helper.
package trap_sequencer_pkg;

  localparam int unsigned XLEN            = 32;
  localparam int unsigned NUM_IRQ_DEF     = 3;
  localparam int unsigned IRQ_CAUSE0_DEF  = 16;
  localparam int unsigned ECALL_CAUSE_DEF = 11;
  localparam int unsigned MCAUSE_INT_BIT  = XLEN - 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SAVE = 2'd1,
    ST_JUMP = 2'd2,
    ST_RET  = 2'd3
  } state_e;

  // mcause value: interrupt flag in the top bit, exception/interrupt code below it
  function automatic logic [XLEN-1:0] mcause_code(input logic is_irq,
                                                  input logic [MCAUSE_INT_BIT-1:0] code);
    return {is_irq, code};
  endfunction

endpackage

// File: rtl/trap_sequencer_irq_pending.sv
// Interrupt edge detection, pending latch and fixed-priority selection
// (index 0 is the highest priority).
module trap_sequencer_irq_pending #(
  parameter int unsigned NUM_IRQ = 3,
  parameter int unsigned IDX_W   = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_IRQ-1:0] irq_in,
  input  logic [NUM_IRQ-1:0] irq_en,
  input  logic               mie,
  input  logic               in_service,
  input  logic [NUM_IRQ-1:0] ack,
  output logic               any_eligible,
  output logic [IDX_W-1:0]   idx
);

  logic [NUM_IRQ-1:0] irq_q;
  logic [NUM_IRQ-1:0] pending;
  logic [NUM_IRQ-1:0] eligible;

  // A new rising edge wins over an acknowledge in the same cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      irq_q   <= '0;
      pending <= '0;
    end else begin
      irq_q   <= irq_in;
      pending <= (pending & ~ack) | (irq_in & ~irq_q);
    end
  end

  assign eligible     = (mie && !in_service) ? (pending & irq_en) : '0;
  assign any_eligible = |eligible;

  always_comb begin
    idx = '0;
    for (int i = int'(NUM_IRQ) - 1; i >= 0; i--) begin
      if (eligible[i]) idx = IDX_W'(i);
    end
  end

endmodule

// File: rtl/trap_sequencer.sv
// Trap entry/exit sequencer: flush, mepc/mcause write, MIE update and PC
// redirect for irq, ecall and mret.
module trap_sequencer
  import trap_sequencer_pkg::*;
#(
  parameter int unsigned NUM_IRQ     = NUM_IRQ_DEF,
  parameter int unsigned IRQ_CAUSE0  = IRQ_CAUSE0_DEF,
  parameter int unsigned ECALL_CAUSE = ECALL_CAUSE_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_IRQ-1:0] irq_in,
  input  logic [NUM_IRQ-1:0] irq_en,
  input  logic               mie,
  input  logic               ex_valid,
  input  logic [XLEN-1:0]    ex_pc,
  input  logic               ecall,
  input  logic               mret,
  input  logic               stall,
  input  logic [XLEN-1:0]    mtvec,
  input  logic [XLEN-1:0]    mepc_in,
  output logic               trap_flush,
  output logic               pc_redirect,
  output logic [XLEN-1:0]    redirect_pc,
  output logic               mepc_we,
  output logic [XLEN-1:0]    mepc_wdata,
  output logic               mcause_we,
  output logic [XLEN-1:0]    mcause_wdata,
  output logic               mie_clr,
  output logic               mie_set,
  output logic [NUM_IRQ-1:0] irq_ack,
  output logic               busy
);

  localparam int unsigned IDX_W = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;

  state_e             state, state_n;
  logic [XLEN-1:0]    cap_pc;
  logic [XLEN-1:0]    cap_cause;
  logic               cap_is_irq;
  logic [IDX_W-1:0]   cap_idx;
  logic               in_service;

  logic               any_eligible;
  logic [IDX_W-1:0]   irq_idx;
  logic               trigger_ok;
  logic               cap_load;
  logic               take_irq;
  logic [XLEN-1:0]    cause_sel;
  logic               set_service;
  logic               clr_service;

  trap_sequencer_irq_pending #(
    .NUM_IRQ (NUM_IRQ),
    .IDX_W   (IDX_W)
  ) u_irq_pending (
    .clk          (clk),
    .rst          (rst),
    .irq_in       (irq_in),
    .irq_en       (irq_en),
    .mie          (mie),
    .in_service   (in_service),
    .ack          (irq_ack),
    .any_eligible (any_eligible),
    .idx          (irq_idx)
  );

  // Gated by rst so nothing is visible while reset is held
  assign trigger_ok = (state == ST_IDLE) && ex_valid && !stall && !rst;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      cap_pc     <= '0;
      cap_cause  <= '0;
      cap_is_irq <= 1'b0;
      cap_idx    <= '0;
      in_service <= 1'b0;
    end else begin
      state <= state_n;
      if (cap_load) begin
        cap_pc     <= ex_pc;
        cap_cause  <= cause_sel;
        cap_is_irq <= take_irq;
        cap_idx    <= irq_idx;
      end
      if (set_service)      in_service <= 1'b1;
      else if (clr_service) in_service <= 1'b0;
    end
  end

  always_comb begin
    state_n      = state;
    trap_flush   = 1'b0;
    pc_redirect  = 1'b0;
    redirect_pc  = '0;
    mepc_we      = 1'b0;
    mepc_wdata   = '0;
    mcause_we    = 1'b0;
    mcause_wdata = '0;
    mie_clr      = 1'b0;
    mie_set      = 1'b0;
    irq_ack      = '0;
    busy         = (state != ST_IDLE);
    cap_load     = 1'b0;
    take_irq     = 1'b0;
    cause_sel    = '0;
    set_service  = 1'b0;
    clr_service  = 1'b0;

    unique case (state)
      ST_IDLE: begin
        if (trigger_ok) begin
          if (mret) begin
            trap_flush = 1'b1;
            state_n    = ST_RET;
          end else if (ecall) begin
            trap_flush = 1'b1;
            cap_load   = 1'b1;
            cause_sel  = mcause_code(1'b0, (XLEN-1)'(ECALL_CAUSE));
            state_n    = ST_SAVE;
          end else if (any_eligible) begin
            trap_flush = 1'b1;
            cap_load   = 1'b1;
            take_irq   = 1'b1;
            cause_sel  = mcause_code(1'b1, (XLEN-1)'(IRQ_CAUSE0 + 32'(irq_idx)));
            state_n    = ST_SAVE;
          end
        end
      end
      ST_SAVE: begin
        trap_flush   = 1'b1;
        mepc_we      = 1'b1;
        mepc_wdata   = cap_pc;
        mcause_we    = 1'b1;
        mcause_wdata = cap_cause;
        mie_clr      = 1'b1;
        if (cap_is_irq) begin
          set_service = 1'b1;
          for (int i = 0; i < int'(NUM_IRQ); i++) begin
            irq_ack[i] = (cap_idx == IDX_W'(i));
          end
        end
        state_n = ST_JUMP;
      end
      ST_JUMP: begin
        trap_flush  = 1'b1;
        pc_redirect = 1'b1;
        redirect_pc = mtvec;
        state_n     = ST_IDLE;
      end
      ST_RET: begin
        trap_flush  = 1'b1;
        pc_redirect = 1'b1;
        redirect_pc = mepc_in;
        mie_set     = 1'b1;
        clr_service = 1'b1;
        state_n     = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

endmodule
